costas_loop_filter: RTL
=======================

// Module: costas_loop_filter
// PURPOSE
//  Costas loop back end, downstream of the I/Q mixer and low-pass FIR stages.
//  Takes filtered I and Q arm samples and forms a sign-based phase error.
//  A proportional-integral (PI) loop filter turns the error into a 32-bit NCO frequency word.
//  An internal FSM writes that word into the NCO frequency register (reg_select=0),
//  replacing the fixed one-shot frequency programming.
// PARAMETERS
//  DW          16            width of signed I/Q samples (LPF output, truncated)
//  FW          32            NCO frequency word / integrator width
//  KP_SHIFT    6             proportional gain = 2^-KP_SHIFT
//  KI_SHIFT    12            integral gain = 2^-KI_SHIFT
//  FREQ_INIT   32'h2000_0000 nominal centre frequency word
//  LOCK_THRESH 8             |err| below this counts as in-lock (lock detector only)
//  LOCK_CNT    16            consecutive in-lock samples needed to assert locked
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active high
//  i_din       in   DW  signed I-arm sample
//  q_din       in   DW  signed Q-arm sample
//  din_valid   in   1   I/Q sample valid strobe (LPF rdy); may be high every cycle
//  nco_we      out  1   NCO register write strobe
//  nco_reg_se  out  1   NCO register select; always 0 (frequency register)
//  nco_data    out  FW  NCO write data
//  freq_word   out  FW  current loop frequency word (debug/monitor)
//  locked      out  1   lock indication
// BEHAVIOUR
//  Reset values: nco_we=0, nco_reg_se=0, nco_data=FREQ_INIT, freq_word=FREQ_INIT,
//   locked=0, integrator=0, FSM=INIT, pending=0.
//  S1 phase detector (on din_valid): err = (i_din>=0) ? q_din : -q_din.
//   I==0 counts as positive. -(-2^(DW-1)) saturates to 2^(DW-1)-1.
//   err and err_v are registered.
//  S2 loop filter (on err_v):
//   e = {err, (FW-DW) zeros}, signed FW.
//   prop = e>>>KP_SHIFT; inc = e>>>KI_SHIFT.
//   integ <= sat(integ+inc). Signed saturation to [-2^(FW-1), 2^(FW-1)-1]; never wraps.
//   freq_word <= FREQ_INIT + integ_new + prop, modulo 2^FW (wrap allowed).
//   pending <= 1.
//  Latency: din_valid at cycle n -> freq_word updated at n+2 -> nco_we high at n+3 if FSM idle.
//  Write FSM:
//   INIT: after rst falls, go to LOAD with data=FREQ_INIT (one startup write).
//   IDLE: if pending -> LOAD, capture freq_word into nco_data, clear pending.
//   LOAD: nco_we=1 for exactly one cycle -> GAP.
//   GAP:  nco_we=0 for one cycle -> IDLE.
//   Max write rate is one per 3 cycles; NCO writes are never back-to-back.
//  Coalescing: updates during LOAD/GAP overwrite freq_word and keep pending set.
//   Only the newest word is written next; intermediate words are dropped, never queued.
//  Simultaneous: if err_v and IDLE->LOAD capture coincide, capture the pre-update word.
//   pending remains set, so the new word is written on the following pass.
//  Reset mid-operation: all state returns to reset values next cycle; an in-flight write is aborted.
//  The INIT write repeats after rst deasserts.
//  nco_data holds its value between writes.
// CONFIGURATION
//  COSTAS_LOCK_DET_EN defined:
//   - Counter increments on each err_v with |err| < LOCK_THRESH, saturating at LOCK_CNT.
//   - locked=1 when the counter reaches LOCK_CNT.
//   - Any err_v with |err| >= LOCK_THRESH clears the counter and locked on the next cycle.
//  Undefined: counter not built; locked tied to 0.
// TESTING (DW=16, FW=32, defaults)
//  1 rst high 4 cycles then low -> single nco_we pulse with nco_data=0x2000_0000, nco_reg_se=0;
//    no further we without din_valid.
//  2 one sample I=100, Q=256 -> freq_word=0x2004_1000 at n+2; nco_we with that data at n+3.
//  3 one sample I=-100, Q=256 from reset -> freq_word=0x1FFB_F000;
//    Q=-32768, I=-1 -> err=32767 (no overflow).
//  4 din_valid every cycle for 10 cycles -> nco_we pulses >=3 cycles apart;
//    final write equals the last freq_word.
//  5 I=1, Q=0x7FFF held for 2^20 samples -> integrator stops at 0x7FFF_FFFF, no sign flip.
//    rst mid-write -> nco_we=0 next cycle, then INIT rewrite.
//  6 COSTAS_LOCK_DET_EN: 16 samples Q=5 -> locked=1 after 16th; then Q=100 -> locked=0 next cycle.
//    Without macro -> locked stays 0.

Source files
------------

// File: rtl/costas_loop_filter.sv
// Costas loop back end: sign-based phase detector, PI loop filter and NCO write FSM.
// Optional lock detector is built when COSTAS_LOCK_DET_EN is defined.
module costas_loop_filter #(
    parameter int unsigned     DW          = 16,
    parameter int unsigned     FW          = 32,
    parameter int unsigned     KP_SHIFT    = 6,
    parameter int unsigned     KI_SHIFT    = 12,
    parameter logic [FW-1:0]   FREQ_INIT   = 32'h2000_0000,
    parameter int unsigned     LOCK_THRESH = 8,
    parameter int unsigned     LOCK_CNT    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] i_din,
    input  logic signed [DW-1:0] q_din,
    input  logic                 din_valid,
    output logic                 nco_we,
    output logic                 nco_reg_se,
    output logic [FW-1:0]        nco_data,
    output logic [FW-1:0]        freq_word,
    output logic                 locked
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_GAP
    } state_t;

    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [FW-1:0] F_MAX = {1'b0, {(FW-1){1'b1}}};
    localparam logic signed [FW-1:0] F_MIN = {1'b1, {(FW-1){1'b0}}};

    logic signed [DW-1:0] err_q, err_d;
    logic                 err_v_q, err_v_d;
    logic signed [FW-1:0] integ_q, integ_d;
    logic [FW-1:0]        freq_word_q, freq_word_d;
    logic [FW-1:0]        nco_data_q, nco_data_d;
    logic                 pending_q, pending_d;
    state_t               state_q, state_d;

    logic signed [FW-1:0] e_ext;
    logic signed [FW-1:0] prop;
    logic signed [FW-1:0] inc;
    logic signed [FW:0]   integ_sum;
    logic signed [FW-1:0] integ_sat;

    // Phase detector: Q arm rectified by the sign of I; negating the most
    // negative sample would overflow, so it is clamped to the positive limit.
    always_comb begin
        err_d   = err_q;
        err_v_d = din_valid;
        if (din_valid) begin
            if (!i_din[DW-1]) begin
                err_d = q_din;
            end else if (q_din == S_MIN) begin
                err_d = S_MAX;
            end else begin
                err_d = -q_din;
            end
        end
    end

    always_comb begin
        e_ext     = {err_q, {(FW-DW){1'b0}}};
        prop      = e_ext >>> KP_SHIFT;
        inc       = e_ext >>> KI_SHIFT;
        integ_sum = {integ_q[FW-1], integ_q} + {inc[FW-1], inc};
        if (integ_sum[FW] != integ_sum[FW-1]) begin
            integ_sat = integ_sum[FW] ? F_MIN : F_MAX;
        end else begin
            integ_sat = integ_sum[FW-1:0];
        end

        integ_d     = integ_q;
        freq_word_d = freq_word_q;
        if (err_v_q) begin
            integ_d     = integ_sat;
            freq_word_d = FREQ_INIT + $unsigned(integ_sat) + $unsigned(prop);
        end
    end

    // A new update arriving on the capture cycle wins over the clear, so the
    // freshly computed word is written on the next pass through IDLE.
    always_comb begin
        state_d    = state_q;
        nco_data_d = nco_data_q;
        pending_d  = pending_q;
        case (state_q)
            ST_INIT: begin
                state_d    = ST_LOAD;
                nco_data_d = FREQ_INIT;
            end
            ST_IDLE: begin
                if (pending_q) begin
                    state_d    = ST_LOAD;
                    nco_data_d = freq_word_q;
                    pending_d  = 1'b0;
                end
            end
            ST_LOAD: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
        if (err_v_q) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= '0;
            err_v_q     <= 1'b0;
            integ_q     <= '0;
            freq_word_q <= FREQ_INIT;
            nco_data_q  <= FREQ_INIT;
            pending_q   <= 1'b0;
            state_q     <= ST_INIT;
        end else begin
            err_q       <= err_d;
            err_v_q     <= err_v_d;
            integ_q     <= integ_d;
            freq_word_q <= freq_word_d;
            nco_data_q  <= nco_data_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
        end
    end

    assign nco_we     = (state_q == ST_LOAD);
    assign nco_reg_se = 1'b0;
    assign nco_data   = nco_data_q;
    assign freq_word  = freq_word_q;

`ifdef COSTAS_LOCK_DET_EN
    localparam int unsigned   CW      = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);
    localparam logic [DW:0]   THR     = (DW+1)'(LOCK_THRESH);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [DW:0]   err_abs;

    always_comb begin
        err_abs    = err_q[DW-1] ? -{err_q[DW-1], err_q} : {err_q[DW-1], err_q};
        lock_cnt_d = lock_cnt_q;
        if (err_v_q) begin
            if (err_abs < THR) begin
                if (lock_cnt_q != CNT_MAX) begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                end
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign locked = (lock_cnt_q == CNT_MAX);
`else
    assign locked = 1'b0;
`endif

endmodule
